// File: rtl/audio_dac_tx_if.sv
// Sample stream from the playback logic into the DAC transmitter.
// The master drives data/valid; the slave returns ready.
interface audio_dac_tx_if;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_dac_tx.sv
// Serial DAC transmitter: buffers one 12-bit sample and, on every sample tick,
// shifts a 16-bit SPI-style frame (sync_n/sclk/din) out to a DAC121S101-class part.
module audio_dac_tx #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned SAMPLE_PERIOD = 2268
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  audio_dac_tx_if.slave        smp,
  output logic                 dac_sync_n,
  output logic                 dac_sclk,
  output logic                 dac_din,
  output logic                 busy,
  output logic                 underrun
);

  localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [11:0]      buf_q, buf_d;
  logic [11:0]      last_q, last_d;
  logic             full_q, full_d;
  logic             ready_q, ready_d;
  logic             sync_n_q, sync_n_d;
  logic             sclk_q, sclk_d;
  logic             din_q, din_d;

  logic             tick;
  logic             xfer;
  logic             idle_tick;
  logic [11:0]      word;
  logic             unused_hi;

  assign unused_hi = ^smp.sample_data[15:12];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    buf_d    = buf_q;
    last_d   = last_q;
    full_d   = full_q;
    sync_n_d = sync_n_q;
    sclk_d   = sclk_q;
    din_d    = din_q;
    word     = last_q;

    tick      = enable && (cnt_q == CNT_LAST);
    xfer      = smp.sample_valid && !full_q;
    idle_tick = tick && (state_q == ST_IDLE);
    underrun  = idle_tick && !full_q && !reset;

    cnt_d = enable ? (tick ? '0 : cnt_q + CNT_W'(1)) : '0;

    // A tick with an empty buffer resends last_sample; a same-cycle transfer
    // is only captured for the following tick.
    if (xfer) begin
      buf_d  = smp.sample_data[11:0];
      full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (idle_tick) begin
          if (full_q) begin
            word   = buf_q;
            last_d = buf_q;
            full_d = 1'b0;
          end
          shreg_d  = {4'b0000, word};
          state_d  = ST_SHIFT;
          bit_d    = '0;
          div_d    = '0;
          sync_n_d = 1'b0;
          sclk_d   = 1'b1;
          din_d    = shreg_d[15];
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b1;
          if (bit_q == 4'd15) begin
            state_d  = ST_GAP;
            sync_n_d = 1'b1;
            din_d    = 1'b0;
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = shreg_q << 1;
            din_d   = shreg_q[14];
          end
        end else begin
          div_d  = div_q + DIV_W'(1);
          sclk_d = (div_d < DIV_HIGH);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = !full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      buf_q    <= '0;
      last_q   <= 12'h800;
      full_q   <= 1'b0;
      ready_q  <= 1'b1;
      sync_n_q <= 1'b1;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      buf_q    <= buf_d;
      last_q   <= last_d;
      full_q   <= full_d;
      ready_q  <= ready_d;
      sync_n_q <= sync_n_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
    end
  end

  assign smp.sample_ready = ready_q;
  assign dac_sync_n       = sync_n_q;
  assign dac_sclk         = sclk_q;
  assign dac_din          = din_q;
  assign busy             = (state_q != ST_IDLE);

endmodule
